// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, load-use/branch stalls,
// jump flush, and a one-entry scoreboard sequencing a multi-cycle MUL/DIV unit.
module hazard_scoreboard_unit #(
  parameter int AW     = 5,
  parameter int MD_LAT = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] Rs_D,
  input  logic [AW-1:0] Rt_D,
  input  logic [AW-1:0] Dst_D,
  input  logic          RegWrite_D,
  input  logic          MD_D,
  input  logic          Branch_D,
  input  logic          Jump_D,
  input  logic [AW-1:0] Rs_E,
  input  logic [AW-1:0] Rt_E,
  input  logic [AW-1:0] WriteReg_E,
  input  logic          RegWrite_E,
  input  logic          MemtoReg_E,
  input  logic          MD_Start_E,
  input  logic [AW-1:0] MD_Dst_E,
  input  logic [AW-1:0] WriteReg_M,
  input  logic [AW-1:0] WriteReg_W,
  input  logic          RegWrite_M,
  input  logic          MemtoReg_M,
  input  logic          RegWrite_W,
  output logic [1:0]    Forward_AE,
  output logic [1:0]    Forward_BE,
  output logic          Forward_AD,
  output logic          Forward_BD,
  output logic          Stall_F,
  output logic          Stall_D,
  output logic          Flush_E,
  output logic          MD_Busy,
  output logic          MD_Done,
  output logic [AW-1:0] MD_Dst,
  output logic          MD_Overrun
);
  localparam int CW = $clog2(MD_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  md_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] dst_q, dst_nxt;
  logic          overrun_q, overrun_nxt;
  logic          lwstall, brstall, mdstall;
  logic          md_raw, md_waw;

  // Sequencer state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      dst_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dst_q     <= dst_nxt;
      overrun_q <= overrun_nxt;
    end
  end

  // Next-state: a start in DONE chains straight into a new op; a start in BUSY is dropped
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    dst_nxt     = dst_q;
    overrun_nxt = overrun_q;
    unique case (state)
      IDLE: if (MD_Start_E) begin
        state_nxt = BUSY;
        cnt_nxt   = CNT_LOAD;
        dst_nxt   = MD_Dst_E;
      end
      BUSY: begin
        cnt_nxt = cnt - 1'b1;
        if (MD_Start_E) overrun_nxt = 1'b1;
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: if (MD_Start_E) begin
        state_nxt = BUSY;
        cnt_nxt   = CNT_LOAD;
        dst_nxt   = MD_Dst_E;
      end else begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer outputs
  always_comb begin
    MD_Busy    = (state == BUSY) || (state == DONE);
    MD_Done    = (state == DONE);
    MD_Dst     = dst_q;
    MD_Overrun = overrun_q;
  end

  // Forwarding: M result has priority over W
  always_comb begin
    Forward_AE = 2'b00;
    if (Rs_E != '0 && Rs_E == WriteReg_M && RegWrite_M)      Forward_AE = 2'b10;
    else if (Rs_E != '0 && Rs_E == WriteReg_W && RegWrite_W) Forward_AE = 2'b01;
    Forward_BE = 2'b00;
    if (Rt_E != '0 && Rt_E == WriteReg_M && RegWrite_M)      Forward_BE = 2'b10;
    else if (Rt_E != '0 && Rt_E == WriteReg_W && RegWrite_W) Forward_BE = 2'b01;
    Forward_AD = (Rs_D != '0) && (Rs_D == WriteReg_M) && RegWrite_M;
    Forward_BD = (Rt_D != '0) && (Rt_D == WriteReg_M) && RegWrite_M;
  end

  // Stalls; in the DONE cycle the write-first register file already supplies the result
  always_comb begin
    lwstall = MemtoReg_E && (WriteReg_E != '0) &&
              ((Rs_D == WriteReg_E) || (Rt_D == WriteReg_E));
    brstall = Branch_D &&
              ((RegWrite_E && (WriteReg_E != '0) &&
                ((WriteReg_E == Rs_D) || (WriteReg_E == Rt_D))) ||
               (MemtoReg_M && (WriteReg_M != '0) &&
                ((WriteReg_M == Rs_D) || (WriteReg_M == Rt_D))));
    md_raw  = (dst_q != '0) && ((Rs_D == dst_q) || (Rt_D == dst_q));
    md_waw  = RegWrite_D && (Dst_D != '0) && (Dst_D == dst_q);
    mdstall = (state == BUSY) && (md_raw || md_waw || MD_D);
    Stall_F = lwstall || brstall || mdstall;
    Stall_D = Stall_F;
    Flush_E = Stall_F || Jump_D;
  end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with hand-computed expectations.
module tb_hazard_scoreboard_unit;
  localparam int AW = 5;
  localparam int MD_LAT = 8;

  logic          CLK, RST;
  logic [AW-1:0] Rs_D, Rt_D, Dst_D, Rs_E, Rt_E, WriteReg_E, MD_Dst_E, WriteReg_M, WriteReg_W;
  logic          RegWrite_D, MD_D, Branch_D, Jump_D, RegWrite_E, MemtoReg_E, MD_Start_E;
  logic          RegWrite_M, MemtoReg_M, RegWrite_W;
  logic [1:0]    Forward_AE, Forward_BE;
  logic          Forward_AD, Forward_BD, Stall_F, Stall_D, Flush_E, MD_Busy, MD_Done, MD_Overrun;
  logic [AW-1:0] MD_Dst;

  int vectors = 0;
  int errors  = 0;

  hazard_scoreboard_unit #(.AW(AW), .MD_LAT(MD_LAT)) dut (
    .CLK(CLK), .RST(RST),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Dst_D(Dst_D),
    .RegWrite_D(RegWrite_D), .MD_D(MD_D), .Branch_D(Branch_D), .Jump_D(Jump_D),
    .Rs_E(Rs_E), .Rt_E(Rt_E), .WriteReg_E(WriteReg_E),
    .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .MD_Start_E(MD_Start_E),
    .MD_Dst_E(MD_Dst_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
    .RegWrite_M(RegWrite_M), .MemtoReg_M(MemtoReg_M), .RegWrite_W(RegWrite_W),
    .Forward_AE(Forward_AE), .Forward_BE(Forward_BE),
    .Forward_AD(Forward_AD), .Forward_BD(Forward_BD),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_E(Flush_E),
    .MD_Busy(MD_Busy), .MD_Done(MD_Done), .MD_Dst(MD_Dst), .MD_Overrun(MD_Overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    {Rs_D, Rt_D, Dst_D, Rs_E, Rt_E, WriteReg_E, MD_Dst_E, WriteReg_M, WriteReg_W} = '0;
    {RegWrite_D, MD_D, Branch_D, Jump_D, RegWrite_E, MemtoReg_E, MD_Start_E} = '0;
    {RegWrite_M, MemtoReg_M, RegWrite_W} = '0;
  endtask

  initial begin
    clear_inputs();
    RST = 1'b0;
    #3;
    check("rst_busy", 32'(MD_Busy), 32'd0);
    check("rst_done", 32'(MD_Done), 32'd0);
    check("rst_dst", 32'(MD_Dst), 32'd0);
    check("rst_overrun", 32'(MD_Overrun), 32'd0);
    check("rst_stall", 32'(Stall_D), 32'd0);
    tick();
    RST = 1'b1;
    tick();

    // E/D forwarding
    Rs_E = 3; WriteReg_M = 3; RegWrite_M = 1; WriteReg_W = 3; RegWrite_W = 1; #1;
    check("fwd_ae_m_over_w", 32'(Forward_AE), 32'd2);
    Rt_E = 3; RegWrite_M = 0; #1;
    check("fwd_be_w", 32'(Forward_BE), 32'd1);
    Rs_E = 0; RegWrite_M = 1; #1;
    check("fwd_ae_r0", 32'(Forward_AE), 32'd0);
    Rs_D = 3; Rt_D = 4; #1;
    check("fwd_ad", 32'(Forward_AD), 32'd1);
    check("fwd_bd", 32'(Forward_BD), 32'd0);
    clear_inputs();

    // Load-use stall and jump flush
    MemtoReg_E = 1; WriteReg_E = 5; Rt_D = 5; #1;
    check("lw_stall_f", 32'(Stall_F), 32'd1);
    check("lw_stall_d", 32'(Stall_D), 32'd1);
    check("lw_flush", 32'(Flush_E), 32'd1);
    WriteReg_E = 0; Rt_D = 0; #1;
    check("lw_r0_nostall", 32'(Stall_D), 32'd0);
    Jump_D = 1; #1;
    check("jump_flush", 32'(Flush_E), 32'd1);
    check("jump_nostall", 32'(Stall_D), 32'd0);
    clear_inputs();

    // RAW scoreboard stall: issue at edge 0, done in cycle 8
    tick();
    MD_Start_E = 1; MD_Dst_E = 9;
    tick();
    MD_Start_E = 0; MD_Dst_E = 0; Rs_D = 9; #1;
    for (int i = 1; i <= 7; i++) begin
      check($sformatf("raw_stall_c%0d", i), 32'(Stall_D), 32'd1);
      check($sformatf("raw_nodone_c%0d", i), 32'(MD_Done), 32'd0);
      tick();
    end
    check("raw_done", 32'(MD_Done), 32'd1);
    check("raw_done_nostall", 32'(Stall_D), 32'd0);
    check("raw_dst", 32'(MD_Dst), 32'd9);
    check("raw_busy_in_done", 32'(MD_Busy), 32'd1);
    tick();
    check("raw_idle", 32'(MD_Busy), 32'd0);
    clear_inputs();

    // Structural stall, then back-to-back issue accepted in DONE
    MD_Start_E = 1; MD_Dst_E = 10;
    tick();
    MD_Start_E = 0; MD_D = 1; #1;
    for (int i = 1; i <= 7; i++) begin
      check($sformatf("md_struct_c%0d", i), 32'(Stall_D), 32'd1);
      tick();
    end
    MD_Start_E = 1; MD_Dst_E = 11; #1;
    check("b2b_done1", 32'(MD_Done), 32'd1);
    check("b2b_struct_release", 32'(Stall_D), 32'd0);
    check("b2b_dst1", 32'(MD_Dst), 32'd10);
    tick();
    MD_Start_E = 0; MD_D = 0; #1;
    for (int i = 1; i <= 7; i++) begin
      check($sformatf("b2b_busy_c%0d", i), 32'(MD_Busy), 32'd1);
      check($sformatf("b2b_nodone_c%0d", i), 32'(MD_Done), 32'd0);
      tick();
    end
    check("b2b_done2", 32'(MD_Done), 32'd1);
    check("b2b_dst2", 32'(MD_Dst), 32'd11);
    check("b2b_no_overrun", 32'(MD_Overrun), 32'd0);
    tick();
    clear_inputs();

    // Overrun: start during BUSY ignored, original op completes on schedule
    MD_Start_E = 1; MD_Dst_E = 12;
    tick();
    MD_Start_E = 0; RegWrite_D = 1; Dst_D = 12; #1;
    check("waw_stall", 32'(Stall_D), 32'd1);
    RegWrite_D = 0; Dst_D = 0;
    tick(); tick();
    MD_Start_E = 1; MD_Dst_E = 13; #1;
    check("ovr_not_yet", 32'(MD_Overrun), 32'd0);
    tick();
    MD_Start_E = 0; MD_Dst_E = 0; #1;
    check("ovr_set", 32'(MD_Overrun), 32'd1);
    check("ovr_dst_kept", 32'(MD_Dst), 32'd12);
    tick(); tick(); tick(); tick();
    check("ovr_done_sched", 32'(MD_Done), 32'd1);
    check("ovr_done_dst", 32'(MD_Dst), 32'd12);
    tick();
    check("ovr_sticky", 32'(MD_Overrun), 32'd1);
    check("ovr_idle", 32'(MD_Busy), 32'd0);

    // Zero destination: sequencer still runs, no scoreboard match
    MD_Start_E = 1; MD_Dst_E = 0;
    tick();
    MD_Start_E = 0; Rs_D = 0; #1;
    check("r0_busy", 32'(MD_Busy), 32'd1);
    check("r0_nostall", 32'(Stall_D), 32'd0);
    for (int i = 1; i <= 7; i++) tick();
    check("r0_done", 32'(MD_Done), 32'd1);
    tick();
    clear_inputs();

    // Reset in BUSY cycle 4 abandons the op
    MD_Start_E = 1; MD_Dst_E = 14;
    tick();
    MD_Start_E = 0; MD_Dst_E = 0;
    tick(); tick(); tick();
    RST = 1'b0; #1;
    check("rst_mid_busy", 32'(MD_Busy), 32'd0);
    check("rst_mid_overrun", 32'(MD_Overrun), 32'd0);
    check("rst_mid_dst", 32'(MD_Dst), 32'd0);
    tick();
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rst_no_done_%0d", i), 32'(MD_Done), 32'd0);
    end

    // Branch stalls
    Branch_D = 1; RegWrite_E = 1; WriteReg_E = 7; Rs_D = 7; #1;
    check("br_stall_e", 32'(Stall_D), 32'd1);
    RegWrite_E = 0; #1;
    check("br_no_stall", 32'(Stall_D), 32'd0);
    MemtoReg_M = 1; WriteReg_M = 7; Rs_D = 0; Rt_D = 7; #1;
    check("br_stall_m", 32'(Stall_F), 32'd1);
    Branch_D = 0; #1;
    check("br_off", 32'(Stall_F), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
